// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus between the two result sources (A = ALU,
// B = load/memory) and the register-file write-back arbiter.
//   a_valid/a_addr/a_data : source A request, held stable until a_ready
//   a_ready               : source A write accepted this cycle
//   b_valid/b_addr/b_data : source B request, held stable until b_ready
//   b_ready               : source B write accepted this cycle
// Modports: master = the sources, slave = the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port.
// One request is granted per clock; the granted write appears on the
// registered write port one cycle later. Writes to R0 complete the handshake
// but never raise D_En. Cycles where both sources request are counted in a
// saturating conflict counter.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   src      : source request bus (slave side)
//   D_En     : register file write enable (registered)
//   D_Addr   : register file write address (registered, holds when idle)
//   D        : register file write data (registered, holds when idle)
//   prio_b   : priority pointer, 0 = A favoured, 1 = B favoured
//   conf_cnt : number of dual-request cycles, saturating
module regfile_wb_arbiter #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    regfile_wb_arbiter_if.slave src,
    output logic              D_En,
    output logic [AW-1:0]     D_Addr,
    output logic [DW-1:0]     D,
    output logic              prio_b,
    output logic [CNTW-1:0]   conf_cnt
);

    logic          both;
    logic          grant_a;
    logic          grant_b;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Readies are gated by reset_n so nothing handshakes while in reset.
    always_comb begin
        both     = src.a_valid & src.b_valid;
        grant_a  = reset_n & src.a_valid & (~src.b_valid | ~prio_b);
        grant_b  = reset_n & src.b_valid & (~src.a_valid |  prio_b);
        sel_addr = grant_b ? src.b_addr : src.a_addr;
        sel_data = grant_b ? src.b_data : src.a_data;
    end

    assign src.a_ready = grant_a;
    assign src.b_ready = grant_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            D_En     <= 1'b0;
            D_Addr   <= '0;
            D        <= '0;
            prio_b   <= 1'b0;
            conf_cnt <= '0;
        end else begin
            if (grant_a | grant_b) begin
                D_Addr <= sel_addr;
                D      <= sel_data;
                D_En   <= (sel_addr != '0);
            end else begin
                D_En   <= 1'b0;
            end

            // Loser of a contested cycle is favoured next time.
            if (both) begin
                prio_b <= grant_a;
            end

            if (both && (conf_cnt != '1)) begin
                conf_cnt <= conf_cnt + CNTW'(1);
            end
        end
    end

endmodule
